// File: rtl/collatz_sweep_multi.sv
// Sweeps DEPTH consecutive start values through LANES parallel Collatz iterators,
// storing each iteration count in a RAM and tracking the sweep maximum.
module collatz_sweep_multi #(
  parameter int WIDTH     = 32,
  parameter int CW        = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int LANES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [WIDTH-1:0]     start,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        max_count,
  output logic [WIDTH-1:0]     max_n,
  output logic                 overflow
);

  localparam int CTRW = ADDR_BITS + 1;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0]   CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_LIMIT = CNT_SAT - CW'(1'b1);
  localparam logic [CTRW-1:0] DEPTH_C   = CTRW'(DEPTH);
  localparam logic [CTRW-1:0] LAST_C    = CTRW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic                  go_acc_s, last_wr_s;
  logic [WIDTH-1:0]      base_r;
  logic [CTRW-1:0]       issued_r, written_r, max_idx_r;
  logic [CW-1:0]         count_r, max_count_r;
  logic [WIDTH-1:0]      max_n_r;
  logic                  busy_r, done_r, overflow_r;

  logic                  lane_busy_r [LANES];
  logic                  lane_rdy_r  [LANES];
  logic [WIDTH-1:0]      lane_n_r    [LANES];
  logic [CW-1:0]         lane_cnt_r  [LANES];
  logic [ADDR_BITS-1:0]  lane_idx_r  [LANES];

  logic [WIDTH+1:0]      trip_s      [LANES];
  logic [WIDTH-1:0]      step_n_s    [LANES];
  logic [CW-1:0]         step_cnt_s  [LANES];
  logic                  step_fin_s  [LANES];

  logic [LANES-1:0]      free_vec_s, rdy_vec_s;
  logic [LW-1:0]         iss_lane_s, wr_lane_s;
  logic                  iss_en_s, wr_en_s, better_s;
  logic [CW-1:0]         wr_cnt_s;
  logic [ADDR_BITS-1:0]  wr_idx_s;

  logic [CW-1:0]         mem_r [2**ADDR_BITS];

  function automatic logic [LW-1:0] prio_idx(input logic [LANES-1:0] v);
    prio_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (v[i]) prio_idx = LW'(i);
      else      prio_idx = prio_idx;
    end
  endfunction

  // Lane arbitration: lowest free lane takes the next issue, lowest ready lane gets the write port
  always_comb begin
    free_vec_s = '0;
    rdy_vec_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      free_vec_s[i] = ~lane_busy_r[i];
      rdy_vec_s[i]  = lane_busy_r[i] & lane_rdy_r[i];
    end
    iss_lane_s = prio_idx(free_vec_s);
    wr_lane_s  = prio_idx(rdy_vec_s);
    iss_en_s   = (state_r == S_RUN) && (issued_r < DEPTH_C) && (|free_vec_s);
    wr_en_s    = |rdy_vec_s;
    wr_cnt_s   = lane_cnt_r[wr_lane_s];
    wr_idx_s   = lane_idx_r[wr_lane_s];
    better_s   = (wr_cnt_s > max_count_r) ||
                 ((wr_cnt_s == max_count_r) && ({1'b0, wr_idx_s} < max_idx_r));
  end

  // One Collatz step per lane; n==0 finishes with count 0, limits finish with the saturation code
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      trip_s[i]     = {2'b00, lane_n_r[i]} + {1'b0, lane_n_r[i], 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
      step_n_s[i]   = lane_n_r[i];
      step_cnt_s[i] = lane_cnt_r[i];
      step_fin_s[i] = 1'b0;
      if (lane_n_r[i] == '0) begin
        step_cnt_s[i] = '0;
        step_fin_s[i] = 1'b1;
      end else if (lane_n_r[i] == WIDTH'(1'b1)) begin
        step_fin_s[i] = 1'b1;
      end else if (lane_cnt_r[i] == CNT_LIMIT) begin
        step_cnt_s[i] = CNT_SAT;
        step_fin_s[i] = 1'b1;
      end else if (!lane_n_r[i][0]) begin
        step_n_s[i]   = lane_n_r[i] >> 1;
        step_cnt_s[i] = lane_cnt_r[i] + CW'(1'b1);
      end else if (trip_s[i][WIDTH+1:WIDTH] != 2'b00) begin
        step_cnt_s[i] = CNT_SAT;
        step_fin_s[i] = 1'b1;
      end else begin
        step_n_s[i]   = trip_s[i][WIDTH-1:0];
        step_cnt_s[i] = lane_cnt_r[i] + CW'(1'b1);
      end
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    go_acc_s     = 1'b0;
    last_wr_s    = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_next_s = S_RUN;
          go_acc_s     = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      S_RUN: begin
        if (wr_en_s && (written_r == LAST_C)) begin
          state_next_s = S_DONE;
          last_wr_s    = 1'b1;
        end else begin
          state_next_s = S_RUN;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM state, sweep counters, max tracking and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      base_r      <= '0;
      issued_r    <= '0;
      written_r   <= '0;
      max_idx_r   <= {CTRW{1'b1}};
      max_count_r <= '0;
      max_n_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_RUN);
      done_r  <= last_wr_s;
      if (go_acc_s) begin
        base_r      <= start;
        issued_r    <= '0;
        written_r   <= '0;
        max_idx_r   <= {CTRW{1'b1}};
        max_count_r <= '0;
        max_n_r     <= '0;
        overflow_r  <= 1'b0;
      end else begin
        if (iss_en_s) issued_r <= issued_r + CTRW'(1'b1);
        if (wr_en_s) begin
          written_r <= written_r + CTRW'(1'b1);
          if (wr_cnt_s == CNT_SAT) overflow_r <= 1'b1;
          if (better_s) begin
            max_count_r <= wr_cnt_s;
            max_idx_r   <= {1'b0, wr_idx_s};
            max_n_r     <= base_r + WIDTH'(wr_idx_s);
          end
        end
      end
    end
  end

  // Lane registers: issue, iterate, then hold the result until the write port is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        lane_busy_r[i] <= 1'b0;
        lane_rdy_r[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (iss_en_s && (iss_lane_s == LW'(i))) begin
          lane_busy_r[i] <= 1'b1;
          lane_rdy_r[i]  <= 1'b0;
          lane_n_r[i]    <= base_r + WIDTH'(issued_r);
          lane_cnt_r[i]  <= CW'(1'b1);
          lane_idx_r[i]  <= issued_r[ADDR_BITS-1:0];
        end else if (wr_en_s && (wr_lane_s == LW'(i))) begin
          lane_busy_r[i] <= 1'b0;
          lane_rdy_r[i]  <= 1'b0;
        end else if (lane_busy_r[i] && !lane_rdy_r[i]) begin
          lane_n_r[i]    <= step_n_s[i];
          lane_cnt_r[i]  <= step_cnt_s[i];
          lane_rdy_r[i]  <= step_fin_s[i];
        end
      end
    end
  end

  // Result RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) mem_r[wr_idx_s] <= wr_cnt_s;
  end

  // Registered readback; same-cycle write returns the old word
  always_ff @(posedge clk) begin
    if (reset) count_r <= '0;
    else       count_r <= mem_r[rd_addr];
  end

  assign count     = count_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign max_count = max_count_r;
  assign max_n     = max_n_r;
  assign overflow  = overflow_r;

endmodule
